// File: rtl/char_spawner.sv
// char_spawner: falling-character slot table for a typing game.
// Spawns random codes into free slots, drops them one row per tick, clears on key hit or bottom miss.
module char_spawner #(
  parameter int SLOTS = 4,
  parameter int ROWS  = 30,
  parameter int ROW_W = 5
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic [7:0]             rdchar,
  input  logic                   spawn,
  input  logic                   fall_tick,
  input  logic                   key_valid,
  input  logic [7:0]             key_code,
  output logic [SLOTS-1:0]       slot_valid,
  output logic [8*SLOTS-1:0]     slot_char,
  output logic [ROW_W*SLOTS-1:0] slot_row,
  output logic                   hit_pulse,
  output logic                   miss_pulse,
  output logic                   drop_pulse,
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt
);
  localparam logic [7:0]       MAX_CODE = 8'd70;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  logic [SLOTS-1:0]            r_valid;
  logic [SLOTS-1:0][7:0]       r_char;
  logic [SLOTS-1:0][ROW_W-1:0] r_row;
  logic                        r_hit_pulse;
  logic                        r_miss_pulse;
  logic                        r_drop_pulse;
  logic [15:0]                 r_hit_cnt;
  logic [15:0]                 r_miss_cnt;

  logic [SLOTS-1:0]            w_match;
  logic [SLOTS-1:0]            w_hit_sel;
  logic [SLOTS-1:0]            w_spawn_sel;
  logic [SLOTS-1:0]            w_miss_mask;
  logic                        w_hit_any;
  logic                        w_free_any;
  logic                        w_code_ok;
  logic                        w_spawn_ok;
  logic [3:0]                  w_miss_num;
  logic [16:0]                 w_miss_sum;
  logic [SLOTS-1:0]            w_valid_nx;
  logic [SLOTS-1:0][7:0]       w_char_nx;
  logic [SLOTS-1:0][ROW_W-1:0] w_row_nx;
  logic [15:0]                 w_hit_cnt_nx;
  logic [15:0]                 w_miss_cnt_nx;

  // Priority pick of the lowest matching slot (key) and lowest free slot (spawn), on pre-edge state.
  always_comb begin
    w_match     = '0;
    w_hit_sel   = '0;
    w_hit_any   = 1'b0;
    w_spawn_sel = '0;
    w_free_any  = 1'b0;
    w_code_ok   = (rdchar != 8'd0) && (rdchar <= MAX_CODE);
    for (int i = 0; i < SLOTS; i++) begin
      w_match[i]     = key_valid && r_valid[i] && (r_char[i] == key_code);
      w_hit_sel[i]   = w_match[i] && !w_hit_any;
      w_hit_any      = w_hit_any || w_match[i];
      w_spawn_sel[i] = !r_valid[i] && !w_free_any;
      w_free_any     = w_free_any || !r_valid[i];
    end
    w_spawn_ok = spawn && w_code_ok && w_free_any;
  end

  // Per-slot update: hit beats fall/miss beats hold; spawn only touches a slot that was already free.
  always_comb begin
    w_valid_nx  = r_valid;
    w_char_nx   = r_char;
    w_row_nx    = r_row;
    w_miss_mask = '0;
    w_miss_num  = 4'd0;
    for (int i = 0; i < SLOTS; i++) begin
      if (w_hit_sel[i]) begin
        w_valid_nx[i] = 1'b0;
        w_row_nx[i]   = '0;
      end else if (fall_tick && r_valid[i]) begin
        if (r_row[i] == LAST_ROW) begin
          w_valid_nx[i]  = 1'b0;
          w_row_nx[i]    = '0;
          w_miss_mask[i] = 1'b1;
        end else begin
          w_row_nx[i] = r_row[i] + ROW_W'(1);
        end
      end else if (w_spawn_ok && w_spawn_sel[i]) begin
        w_valid_nx[i] = 1'b1;
        w_char_nx[i]  = rdchar;
        w_row_nx[i]   = '0;
      end else begin
        w_valid_nx[i] = r_valid[i];
      end
      w_miss_num = w_miss_num + 4'(w_miss_mask[i]);
    end
    w_miss_sum    = {1'b0, r_miss_cnt} + 17'(w_miss_num);
    w_miss_cnt_nx = w_miss_sum[16] ? CNT_MAX : w_miss_sum[15:0];
    if (w_hit_any && (r_hit_cnt != CNT_MAX)) begin
      w_hit_cnt_nx = r_hit_cnt + 16'd1;
    end else begin
      w_hit_cnt_nx = r_hit_cnt;
    end
  end

  // Slot table, event pulses and score counters.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid      <= '0;
      r_char       <= '0;
      r_row        <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_drop_pulse <= 1'b0;
      r_hit_cnt    <= 16'd0;
      r_miss_cnt   <= 16'd0;
    end else begin
      r_valid      <= w_valid_nx;
      r_char       <= w_char_nx;
      r_row        <= w_row_nx;
      r_hit_pulse  <= w_hit_any;
      r_miss_pulse <= (w_miss_num != 4'd0);
      r_drop_pulse <= spawn && !w_spawn_ok;
      r_hit_cnt    <= w_hit_cnt_nx;
      r_miss_cnt   <= w_miss_cnt_nx;
    end
  end

  assign slot_valid = r_valid;
  assign slot_char  = r_char;
  assign slot_row   = r_row;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign drop_pulse = r_drop_pulse;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;
endmodule

// File: tb/tb_char_spawner.sv
// Self-checking bench for char_spawner: directed table, corner sequences, random vs. reference model,
// async reset and a parallel small-ROWS instance for counter saturation.
module tb_char_spawner;
  localparam int NS = 4;
  localparam int NR = 30;

  logic        clk = 1'b0;
  logic        clrn;
  logic [7:0]  rdchar, key_code;
  logic        spawn, fall_tick, key_valid;
  logic [3:0]  slot_valid;
  logic [31:0] slot_char;
  logic [19:0] slot_row;
  logic        hit_pulse, miss_pulse, drop_pulse;
  logic [15:0] hit_cnt, miss_cnt;

  logic        s_clrn, s_spawn, s_fall, s_kv;
  logic [7:0]  s_rd, s_kc;
  logic [3:0]  s_valid;
  logic [31:0] s_char;
  logic [3:0]  s_row;
  logic        s_hit_p, s_miss_p, s_drop_p;
  logic [15:0] s_hit_cnt, s_miss_cnt;
  bit          sat_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  char_spawner #(.SLOTS(NS), .ROWS(NR), .ROW_W(5)) dut (
    .clk(clk), .clrn(clrn), .rdchar(rdchar), .spawn(spawn), .fall_tick(fall_tick),
    .key_valid(key_valid), .key_code(key_code), .slot_valid(slot_valid), .slot_char(slot_char),
    .slot_row(slot_row), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .drop_pulse(drop_pulse),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  char_spawner #(.SLOTS(4), .ROWS(2), .ROW_W(1)) dut_sat (
    .clk(clk), .clrn(s_clrn), .rdchar(s_rd), .spawn(s_spawn), .fall_tick(s_fall),
    .key_valid(s_kv), .key_code(s_kc), .slot_valid(s_valid), .slot_char(s_char),
    .slot_row(s_row), .hit_pulse(s_hit_p), .miss_pulse(s_miss_p), .drop_pulse(s_drop_p),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt));

  // Reference model state
  bit         m_valid[NS];
  logic [7:0] m_char[NS];
  int         m_row[NS];
  int         m_hit_cnt, m_miss_cnt;
  bit         m_hit, m_miss, m_drop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0; m_char[i] = 8'd0; m_row[i] = 0;
    end
    m_hit_cnt = 0; m_miss_cnt = 0; m_hit = 1'b0; m_miss = 1'b0; m_drop = 1'b0;
  endtask

  task automatic model_step(input bit sp, input logic [7:0] rc, input bit ft,
                            input bit kv, input logic [7:0] kc);
    int  hit_idx = -1;
    int  free_idx = -1;
    int  misses = 0;
    bit  pre[NS];
    for (int i = 0; i < NS; i++) pre[i] = m_valid[i];
    if (kv)
      for (int i = 0; i < NS; i++)
        if (hit_idx < 0 && pre[i] && m_char[i] == kc) hit_idx = i;
    if (sp && rc >= 1 && rc <= 70)
      for (int i = 0; i < NS; i++)
        if (free_idx < 0 && !pre[i]) free_idx = i;
    for (int i = 0; i < NS; i++) begin
      if (i == hit_idx) begin
        m_valid[i] = 1'b0;
      end else if (ft && pre[i]) begin
        if (m_row[i] == NR - 1) begin
          m_valid[i] = 1'b0; m_row[i] = 0; misses++;
        end else begin
          m_row[i]++;
        end
      end
    end
    if (free_idx >= 0) begin
      m_valid[free_idx] = 1'b1; m_char[free_idx] = rc; m_row[free_idx] = 0;
    end
    m_hit      = (hit_idx >= 0);
    m_miss     = (misses > 0);
    m_drop     = sp && (free_idx < 0);
    m_hit_cnt  = (m_hit_cnt + int'(m_hit) > 65535) ? 65535 : m_hit_cnt + int'(m_hit);
    m_miss_cnt = (m_miss_cnt + misses > 65535) ? 65535 : m_miss_cnt + misses;
  endtask

  task automatic cmp_model(input string tag);
    logic [3:0]  ev;
    logic [31:0] ec;
    logic [19:0] er, ar;
    for (int i = 0; i < NS; i++) begin
      ev[i]        = m_valid[i];
      ec[8*i +: 8] = m_char[i];
      er[5*i +: 5] = m_valid[i] ? 5'(m_row[i]) : 5'd0;
      ar[5*i +: 5] = m_valid[i] ? slot_row[5*i +: 5] : 5'd0;
    end
    chk({tag, ".valid"}, slot_valid, ev);
    chk({tag, ".char"}, slot_char, ec);
    chk({tag, ".row"}, ar, er);
    chk({tag, ".hit_pulse"}, hit_pulse, m_hit);
    chk({tag, ".miss_pulse"}, miss_pulse, m_miss);
    chk({tag, ".drop_pulse"}, drop_pulse, m_drop);
    chk({tag, ".hit_cnt"}, hit_cnt, 16'(m_hit_cnt));
    chk({tag, ".miss_cnt"}, miss_cnt, 16'(m_miss_cnt));
  endtask

  task automatic step(input string tag, input bit sp, input logic [7:0] rc, input bit ft,
                      input bit kv, input logic [7:0] kc);
    spawn = sp; rdchar = rc; fall_tick = ft; key_valid = kv; key_code = kc;
    @(posedge clk);
    model_step(sp, rc, ft, kv, kc);
    #1;
    cmp_model(tag);
  endtask

  typedef struct {
    bit         sp;
    logic [7:0] rc;
    bit         ft;
    bit         kv;
    logic [7:0] kc;
    logic [3:0] e_valid;
    bit         e_drop;
    bit         e_hit;
    logic [15:0] e_hit_cnt;
  } vec_t;

  vec_t tbl[22];

  // Saturation: ROWS=2, spawn and fall every cycle -> one miss per edge from the third edge on.
  initial begin
    s_clrn = 1'b0; s_spawn = 1'b0; s_fall = 1'b0; s_kv = 1'b0; s_kc = 8'd0; s_rd = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    s_clrn = 1'b1; s_spawn = 1'b1; s_fall = 1'b1;
    for (int n = 1; n <= 65600; n++) begin
      @(posedge clk);
      #1;
      if (n == 1000) chk("sat_mid_miss_cnt", s_miss_cnt, 64'd998);
    end
    chk("sat_full_miss_cnt", s_miss_cnt, 64'hFFFF);
    chk("sat_miss_pulse", s_miss_p, 64'd1);
    sat_done = 1'b1;
  end

  initial begin
    tbl[0]  = '{1'b1, 8'd23, 1'b0, 1'b0, 8'd0,  4'b0001, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd23, 4'b0000, 1'b0, 1'b1, 16'd1};
    tbl[2]  = '{1'b1, 8'd0,  1'b0, 1'b0, 8'd0,  4'b0000, 1'b1, 1'b0, 16'd1};
    tbl[3]  = '{1'b1, 8'd1,  1'b0, 1'b0, 8'd0,  4'b0001, 1'b0, 1'b0, 16'd1};
    tbl[4]  = '{1'b1, 8'd2,  1'b0, 1'b0, 8'd0,  4'b0011, 1'b0, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 8'd3,  1'b0, 1'b0, 8'd0,  4'b0111, 1'b0, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 8'd4,  1'b0, 1'b0, 8'd0,  4'b1111, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 8'd5,  1'b0, 1'b0, 8'd0,  4'b1111, 1'b1, 1'b0, 16'd1};
    tbl[8]  = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd2,  4'b1101, 1'b0, 1'b1, 16'd2};
    tbl[9]  = '{1'b1, 8'd71, 1'b0, 1'b0, 8'd0,  4'b1101, 1'b1, 1'b0, 16'd2};
    tbl[10] = '{1'b1, 8'd7,  1'b0, 1'b0, 8'd0,  4'b1111, 1'b0, 1'b0, 16'd2};
    tbl[11] = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd1,  4'b1110, 1'b0, 1'b1, 16'd3};
    tbl[12] = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd7,  4'b1100, 1'b0, 1'b1, 16'd4};
    tbl[13] = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd3,  4'b1000, 1'b0, 1'b1, 16'd5};
    tbl[14] = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd4,  4'b0000, 1'b0, 1'b1, 16'd6};
    tbl[15] = '{1'b1, 8'd7,  1'b0, 1'b0, 8'd0,  4'b0001, 1'b0, 1'b0, 16'd6};
    tbl[16] = '{1'b1, 8'd9,  1'b0, 1'b0, 8'd0,  4'b0011, 1'b0, 1'b0, 16'd6};
    tbl[17] = '{1'b1, 8'd7,  1'b0, 1'b0, 8'd0,  4'b0111, 1'b0, 1'b0, 16'd6};
    tbl[18] = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd7,  4'b0110, 1'b0, 1'b1, 16'd7};
    tbl[19] = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd8,  4'b0110, 1'b0, 1'b0, 16'd7};
    tbl[20] = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd7,  4'b0010, 1'b0, 1'b1, 16'd8};
    tbl[21] = '{1'b0, 8'd0,  1'b0, 1'b1, 8'd9,  4'b0000, 1'b0, 1'b1, 16'd9};

    clrn = 1'b0; spawn = 1'b0; rdchar = 8'd0; fall_tick = 1'b0; key_valid = 1'b0; key_code = 8'd0;
    model_reset();
    #12;
    chk("reset.valid", slot_valid, 64'd0);
    chk("reset.char", slot_char, 64'd0);
    chk("reset.row", slot_row, 64'd0);
    chk("reset.pulses", {hit_pulse, miss_pulse, drop_pulse}, 64'd0);
    chk("reset.cnts", {hit_cnt, miss_cnt}, 64'd0);
    clrn = 1'b1;

    for (int v = 0; v < 22; v++) begin
      step($sformatf("tbl%0d", v), tbl[v].sp, tbl[v].rc, tbl[v].ft, tbl[v].kv, tbl[v].kc);
      chk($sformatf("tbl%0d.valid", v), slot_valid, tbl[v].e_valid);
      chk($sformatf("tbl%0d.drop", v), drop_pulse, tbl[v].e_drop);
      chk($sformatf("tbl%0d.hit", v), hit_pulse, tbl[v].e_hit);
      chk($sformatf("tbl%0d.hit_cnt", v), hit_cnt, tbl[v].e_hit_cnt);
      if (v == 0) chk("first_spawn.char0", slot_char[7:0], 64'd23);
    end
    chk("table_slot2_char", slot_char[23:16], 64'd7);

    // Fall to the bottom row and off it
    step("fall.spawn", 1'b1, 8'd9, 1'b0, 1'b0, 8'd0);
    for (int t = 0; t < 29; t++) step("fall.tick", 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
    chk("fall.row29", slot_row[4:0], 64'd29);
    chk("fall.valid29", slot_valid, 64'd1);
    step("fall.last", 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
    chk("fall.cleared", slot_valid, 64'd0);
    chk("fall.miss_pulse", miss_pulse, 64'd1);
    chk("fall.miss_cnt", miss_cnt, 64'd1);
    step("fall.idle", 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    chk("fall.miss_pulse_end", miss_pulse, 64'd0);

    // Hit, fall and spawn all in one cycle
    step("sim.spawn5", 1'b1, 8'd5, 1'b0, 1'b0, 8'd0);
    for (int t = 0; t < 29; t++) step("sim.tick", 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
    step("sim.fill1", 1'b1, 8'd10, 1'b0, 1'b0, 8'd0);
    step("sim.fill2", 1'b1, 8'd11, 1'b0, 1'b0, 8'd0);
    step("sim.fill3", 1'b1, 8'd12, 1'b0, 1'b0, 8'd0);
    step("sim.all", 1'b1, 8'd6, 1'b1, 1'b1, 8'd5);
    chk("sim.valid", slot_valid, 64'b1110);
    chk("sim.drop", drop_pulse, 64'd1);
    chk("sim.hit", hit_pulse, 64'd1);
    chk("sim.hit_cnt", hit_cnt, 64'd10);
    chk("sim.miss_cnt", miss_cnt, 64'd1);
    step("sim.respawn", 1'b1, 8'd6, 1'b0, 1'b0, 8'd0);
    chk("sim.respawn_valid", slot_valid, 64'b1111);
    chk("sim.respawn_char", slot_char[7:0], 64'd6);
    chk("sim.respawn_row", slot_row[4:0], 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      bit sp, ft, kv;
      logic [7:0] rc, kc;
      sp = ($urandom_range(0, 2) == 0);
      ft = ($urandom_range(0, 1) == 0);
      kv = ($urandom_range(0, 3) == 0);
      rc = 8'($urandom_range(0, 80));
      kc = ($urandom_range(0, 1) == 0) ? m_char[$urandom_range(0, NS - 1)] : 8'($urandom_range(0, 75));
      step("rand", sp, rc, ft, kv, kc);
    end

    // Asynchronous reset between edges
    #3;
    clrn = 1'b0;
    spawn = 1'b0; fall_tick = 1'b0; key_valid = 1'b0;
    #1;
    chk("areset.valid", slot_valid, 64'd0);
    chk("areset.char", slot_char, 64'd0);
    chk("areset.row", slot_row, 64'd0);
    chk("areset.pulses", {hit_pulse, miss_pulse, drop_pulse}, 64'd0);
    chk("areset.cnts", {hit_cnt, miss_cnt}, 64'd0);
    model_reset();
    #2;
    clrn = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step("rand2", ($urandom_range(0, 1) == 0), 8'($urandom_range(0, 72)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           m_char[$urandom_range(0, NS - 1)]);
    end

    for (int c = 0; c < 80000 && !sat_done; c++) @(posedge clk);
    chk("sat_done", sat_done, 64'd1);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
